branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the RISC-V fetch stage.
- Supplies fetch with a predicted next PC and a pc_sel code, using the same pc_sel encoding the fetch mux already decodes plus one new code.
- Trains from branches resolved in execute, detects mispredicts and produces the redirect PC.
- Keeps saturating performance counters for branches and mispredicts.

Parameters:
- IDX_BITS, 4, log2 of entry count (ENTRIES = 2^IDX_BITS).
- TAG_BITS, 8, tag width stored per entry.
- CTR_BITS, 2, direction counter width (>=1).
- PC_WIDTH, 32, PC width; must satisfy PC_WIDTH >= IDX_BITS+TAG_BITS+2.
- PERF_BITS, 32, width of performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- f_pc  in  PC_WIDTH  fetch PC being looked up.
- pred_taken  out  1  lookup hit and counter predicts taken.
- pred_target  out  PC_WIDTH  predicted next PC.
- x_valid  in  1  execute stage holds a resolved branch.
- x_pc  in  PC_WIDTH  PC of the resolved branch.
- x_taken  in  1  actual direction.
- x_target  in  PC_WIDTH  actual taken target.
- x_pred_taken  in  1  prediction carried down the pipe with this branch.
- x_pred_target  in  PC_WIDTH  predicted target carried down the pipe.
- mispredict  out  1  execute-stage prediction was wrong.
- redirect_pc  out  PC_WIDTH  correct next PC on mispredict.
- pc_sel  out  3  fetch mux select.
- branch_count  out  PERF_BITS  resolved branches.
- mispredict_count  out  PERF_BITS  mispredicts.

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. Per entry: valid, tag, target, ctr.
- Lookup is combinational from registered state (0-cycle): hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[CTR_BITS-1].
  - pred_target = pred_taken ? target[idx] : f_pc+4 (modulo 2^PC_WIDTH).
- mispredict = !rst && x_valid && (x_pred_taken != x_taken || (x_taken && x_pred_target != x_target)).
- redirect_pc = x_taken ? x_target : x_pc+4.
- pc_sel priority:
  - rst -> 0;
  - mispredict -> 3;
  - pred_taken -> 4;
  - otherwise -> 2.
  - Codes 1, 5, 6, 7 are never driven by this block.
- Update at posedge when x_valid && !rst:
  - Hit on x_pc: ctr increments when taken, decrements when not taken; saturates at 0 and 2^CTR_BITS-1. Target is written only when taken.
  - Miss and taken: allocate/overwrite the entry with valid=1, tag, target=x_target, ctr=2^(CTR_BITS-1) (weakly taken).
  - Miss and not taken: no table change.
- Simultaneous lookup and update of the same index: lookup returns pre-update contents; no bypass.
- Perf counters, when x_valid: branch_count += 1; mispredict_count += 1 if mispredict. Both saturate at all-ones and never wrap.
- Reset (any cycle, including mid-update), next cycle:
  - all valid=0;
  - all ctr = 2^(CTR_BITS-1)-1 (weakly not taken);
  - targets and tags = 0;
  - perf counters = 0.
  - During rst: pred_taken=0, pred_target=f_pc+4, mispredict=0, pc_sel=0, and any x_valid that cycle is ignored.
- CTR_BITS=1: counter is a last-outcome bit; allocation sets it to 1.

Test Plan:
- Reset, f_pc=0x100 -> pred_taken=0, pred_target=0x104, pc_sel=2; both counts 0.
- x_valid, x_pc=0x100, taken, x_target=0x200, x_pred_taken=0 -> mispredict=1, redirect_pc=0x200, pc_sel=3; next cycle f_pc=0x100 gives pred_taken=1, pred_target=0x200, pc_sel=4, mispredict_count=1.
- Alias check: f_pc=0x100+(1<<(IDX_BITS+2)) (same index, different tag) -> pred_taken=0.
- Train 0x100 not-taken twice from weakly taken -> ctr 2->1->0, pred_taken=0; three more not-taken keep ctr at 0; then taken once -> ctr=1, still not predicted taken.
- Same cycle f_pc=x_pc=0x100 with allocating update -> lookup shows pre-update miss; the following cycle shows a hit.
- Assert rst during an x_valid taken update -> no allocation; after release pred_taken=0 and counts are 0.
- Force mispredict_count to all-ones (PERF_BITS=4 build, 16 mispredicts) -> the count holds at 15.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from registered table state; training happens
// at posedge from branches resolved in execute. Also detects mispredicts,
// produces the redirect PC and keeps saturating branch/mispredict counts.
module branch_predict_unit #(
    parameter int IDX_BITS  = 4,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int PC_WIDTH  = 32,
    parameter int PERF_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  f_pc,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    input  logic                 x_valid,
    input  logic [PC_WIDTH-1:0]  x_pc,
    input  logic                 x_taken,
    input  logic [PC_WIDTH-1:0]  x_target,
    input  logic                 x_pred_taken,
    input  logic [PC_WIDTH-1:0]  x_pred_target,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [2:0]           pc_sel,
    output logic [PERF_BITS-1:0] branch_count,
    output logic [PERF_BITS-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_BITS;

    // Counter encodings: MSB set means "predict taken".
    localparam logic [CTR_BITS-1:0] CTR_MAX     = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_BITS'(1);

    // Fetch mux select codes shared with the existing fetch stage decoder.
    localparam logic [2:0] PCSEL_RST   = 3'd0;
    localparam logic [2:0] PCSEL_SEQ   = 3'd2;
    localparam logic [2:0] PCSEL_REDIR = 3'd3;
    localparam logic [2:0] PCSEL_PRED  = 3'd4;

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    // Saturating up/down step of a direction counter.
    function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] c,
                                                     input logic up);
        if (up) begin
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        end
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    // Saturating increment of a performance counter.
    function automatic logic [PERF_BITS-1:0] perf_inc(input logic [PERF_BITS-1:0] c,
                                                      input logic en);
        if (en && (c != {PERF_BITS{1'b1}})) begin
            return c + PERF_BITS'(1);
        end
        return c;
    endfunction

    // Table state.
    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0]  target_q [ENTRIES];
    logic [CTR_BITS-1:0]  ctr_q    [ENTRIES];

    logic [PERF_BITS-1:0] branch_count_q, branch_count_d;
    logic [PERF_BITS-1:0] mispredict_count_q, mispredict_count_d;

    // Lookup and training index/tag fields.
    logic [IDX_BITS-1:0] f_idx, x_idx;
    logic [TAG_BITS-1:0] f_tag, x_tag;
    logic                f_hit, x_hit;

    assign f_idx = f_pc[IDX_BITS+1:2];
    assign f_tag = f_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign x_idx = x_pc[IDX_BITS+1:2];
    assign x_tag = x_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

    // Prediction is read from pre-update state; no same-cycle bypass.
    always_comb begin
        pred_taken  = !rst && f_hit && ctr_q[f_idx][CTR_BITS-1];
        pred_target = pred_taken ? target_q[f_idx] : f_pc + PC_STEP;
    end

    // Mispredict detection, redirect target and fetch mux select.
    always_comb begin
        mispredict  = !rst && x_valid &&
                      ((x_pred_taken != x_taken) ||
                       (x_taken && (x_pred_target != x_target)));
        redirect_pc = x_taken ? x_target : x_pc + PC_STEP;
        if (rst) begin
            pc_sel = PCSEL_RST;
        end else if (mispredict) begin
            pc_sel = PCSEL_REDIR;
        end else if (pred_taken) begin
            pc_sel = PCSEL_PRED;
        end else begin
            pc_sel = PCSEL_SEQ;
        end
    end

    // Next-state for the single entry touched by a resolved branch.
    logic                ent_wr;
    logic [PC_WIDTH-1:0] ent_target_d;
    logic [CTR_BITS-1:0] ent_ctr_d;

    always_comb begin
        ent_wr       = 1'b0;
        ent_target_d = target_q[x_idx];
        ent_ctr_d    = ctr_q[x_idx];
        if (x_valid) begin
            if (x_hit) begin
                ent_wr    = 1'b1;
                ent_ctr_d = ctr_step(ctr_q[x_idx], x_taken);
                if (x_taken) begin
                    ent_target_d = x_target;
                end
            end else if (x_taken) begin
                // Allocate (or evict an alias) as weakly taken.
                ent_wr       = 1'b1;
                ent_ctr_d    = CTR_WEAK_T;
                ent_target_d = x_target;
            end
        end
    end

    // Next-state for the saturating performance counters.
    always_comb begin
        branch_count_d     = perf_inc(branch_count_q, x_valid);
        mispredict_count_d = perf_inc(mispredict_count_q, mispredict);
    end

    // Table and counter registers; reset takes priority over any update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q            <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
            if (ent_wr) begin
                valid_q[x_idx]  <= 1'b1;
                tag_q[x_idx]    <= x_tag;
                target_q[x_idx] <= ent_target_d;
                ctr_q[x_idx]    <= ent_ctr_d;
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit: a default build plus a
// PERF_BITS=4 build used to exercise performance counter saturation.
module tb_branch_predict_unit;

    localparam int PCW = 32;

    logic           clk;
    logic           rst;
    logic [PCW-1:0] f_pc;
    logic           x_valid;
    logic           x_valid_b;
    logic [PCW-1:0] x_pc;
    logic           x_taken;
    logic [PCW-1:0] x_target;
    logic           x_pred_taken;
    logic [PCW-1:0] x_pred_target;

    logic           pred_taken, mispredict;
    logic [PCW-1:0] pred_target, redirect_pc;
    logic [2:0]     pc_sel;
    logic [31:0]    branch_count, mispredict_count;

    logic           pred_taken_b, mispredict_b;
    logic [PCW-1:0] pred_target_b, redirect_pc_b;
    logic [2:0]     pc_sel_b;
    logic [3:0]     branch_count_b, mispredict_count_b;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mp = 0;

    branch_predict_unit dut (
        .clk(clk), .rst(rst), .f_pc(f_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .x_valid(x_valid), .x_pc(x_pc), .x_taken(x_taken), .x_target(x_target),
        .x_pred_taken(x_pred_taken), .x_pred_target(x_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .pc_sel(pc_sel),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    branch_predict_unit #(.PERF_BITS(4)) dut_b (
        .clk(clk), .rst(rst), .f_pc(f_pc),
        .pred_taken(pred_taken_b), .pred_target(pred_target_b),
        .x_valid(x_valid_b), .x_pc(x_pc), .x_taken(x_taken), .x_target(x_target),
        .x_pred_taken(x_pred_taken), .x_pred_target(x_pred_target),
        .mispredict(mispredict_b), .redirect_pc(redirect_pc_b), .pc_sel(pc_sel_b),
        .branch_count(branch_count_b), .mispredict_count(mispredict_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one resolved branch on dut, check its execute-side outputs, clock it in.
    task automatic do_branch(input string tag, input logic [PCW-1:0] pc, input logic tk,
                             input logic [PCW-1:0] tgt, input logic ptk,
                             input logic [PCW-1:0] ptgt, input logic exp_mis);
        x_valid       = 1'b1;
        x_pc          = pc;
        x_taken       = tk;
        x_target      = tgt;
        x_pred_taken  = ptk;
        x_pred_target = ptgt;
        #1;
        check({tag, "_mis"}, 64'(mispredict), 64'(exp_mis));
        check({tag, "_redir"}, 64'(redirect_pc), tk ? 64'(tgt) : 64'(pc + 32'd4));
        if (exp_mis) check({tag, "_pcsel"}, 64'(pc_sel), 64'd3);
        exp_br++;
        if (exp_mis) exp_mp++;
        tick();
        x_valid = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [PCW-1:0] pc, input logic exp_tk,
                        input logic [PCW-1:0] exp_tgt, input logic [2:0] exp_sel);
        f_pc = pc;
        #1;
        check({tag, "_ptk"}, 64'(pred_taken), 64'(exp_tk));
        check({tag, "_ptgt"}, 64'(pred_target), 64'(exp_tgt));
        check({tag, "_sel"}, 64'(pc_sel), 64'(exp_sel));
    endtask

    initial begin
        rst = 1'b1; f_pc = 32'h100;
        x_valid = 1'b1; x_valid_b = 1'b0;
        x_pc = 32'h100; x_taken = 1'b1; x_target = 32'h200;
        x_pred_taken = 1'b0; x_pred_target = 32'h0;
        tick();
        // During reset: outputs forced and the taken branch is ignored.
        check("rst_ptk", 64'(pred_taken), 64'd0);
        check("rst_ptgt", 64'(pred_target), 64'h104);
        check("rst_sel", 64'(pc_sel), 64'd0);
        check("rst_mis", 64'(mispredict), 64'd0);
        tick();
        rst = 1'b0; x_valid = 1'b0;
        #1;
        look("post_rst", 32'h100, 1'b0, 32'h104, 3'd2);
        check("post_rst_bc", 64'(branch_count), 64'd0);
        check("post_rst_mc", 64'(mispredict_count), 64'd0);

        // Allocating update with same-cycle lookup of the same PC: pre-update miss.
        f_pc = 32'h100;
        x_valid = 1'b1;
        #1;
        check("same_cyc_ptk", 64'(pred_taken), 64'd0);
        do_branch("alloc", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        look("hit", 32'h100, 1'b1, 32'h200, 3'd4);
        check("hit_mc", 64'(mispredict_count), 64'd1);
        check("hit_bc", 64'(branch_count), 64'd1);

        // Same index, different tag.
        look("alias", 32'h140, 1'b0, 32'h144, 3'd2);

        // Train down: ctr 2 -> 1 -> 0, then saturate at 0.
        f_pc = 32'h100;
        do_branch("nt1", 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        look("nt1", 32'h100, 1'b0, 32'h104, 3'd2);
        do_branch("nt2", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_branch("nt3", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_branch("nt4", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        do_branch("nt5", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look("nt5", 32'h100, 1'b0, 32'h104, 3'd2);
        // One taken from 0 -> ctr 1, still not taken.
        do_branch("t1", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        look("t1", 32'h100, 1'b0, 32'h104, 3'd2);
        // Another taken -> ctr 2, predicted taken with retained target.
        do_branch("t2", 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
        look("t2", 32'h100, 1'b1, 32'h200, 3'd4);
        // Taken to a new target: target mispredict, target rewritten, ctr 3.
        do_branch("t3", 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1);
        look("t3", 32'h100, 1'b1, 32'h300, 3'd4);
        // Correct prediction; ctr saturates at 3.
        do_branch("t4", 32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
        // One not-taken from 3 -> 2, still taken, target kept.
        do_branch("nt6", 32'h100, 1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
        look("nt6", 32'h100, 1'b1, 32'h300, 3'd4);
        check("train_bc", 64'(branch_count), 64'(exp_br));
        check("train_mc", 64'(mispredict_count), 64'(exp_mp));
        check("train_bc_abs", 64'(branch_count), 64'd11);
        check("train_mc_abs", 64'(mispredict_count), 64'd6);

        // Reset during a taken update on a fresh index.
        rst = 1'b1;
        x_valid = 1'b1; x_pc = 32'h184; x_taken = 1'b1; x_target = 32'h280;
        x_pred_taken = 1'b0; x_pred_target = 32'h0;
        #1;
        check("midrst_mis", 64'(mispredict), 64'd0);
        check("midrst_sel", 64'(pc_sel), 64'd0);
        check("midrst_ptk", 64'(pred_taken), 64'd0);
        tick();
        rst = 1'b0; x_valid = 1'b0;
        #1;
        look("midrst_new", 32'h184, 1'b0, 32'h188, 3'd2);
        look("midrst_old", 32'h100, 1'b0, 32'h104, 3'd2);
        check("midrst_bc", 64'(branch_count), 64'd0);
        check("midrst_mc", 64'(mispredict_count), 64'd0);

        // PERF_BITS=4 build: 16 mispredicting branches saturate at 15.
        x_pc = 32'h100; x_taken = 1'b1; x_target = 32'h200;
        x_pred_taken = 1'b0; x_pred_target = 32'h0;
        x_valid_b = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("sat15_mc", 64'(mispredict_count_b), 64'd15);
        tick();
        x_valid_b = 1'b0;
        #1;
        check("sat16_mc", 64'(mispredict_count_b), 64'd15);
        check("sat16_bc", 64'(branch_count_b), 64'd15);
        check("sat_other_mc", 64'(mispredict_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
